pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Program-counter controller that sequences the MIPS single-cycle datapath.
- Loads a boot vector, then advances the PC sequentially or redirects it on branch, jump or register-jump.
- Holds the PC on stall, and stops fetch on halt.
- Sits between the control unit and the instruction memory address port; `pc` drives fetch directly.

Parameters:
- RESET_VEC, 32'h0000_0000, PC value held while in reset and in IDLE.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- boot  input  1  start pulse; loads `pc_in` when in IDLE or HALT.
- pc_in  input  32  boot vector.
- stall  input  1  hold the PC; the current instruction re-issues.
- halt_req  input  1  stop fetching.
- branch_taken  input  1  conditional branch resolved taken.
- branch_off  input  16  signed word offset.
- jump  input  1  J-type jump.
- jump_target  input  26  J-type target field.
- jr  input  1  register jump.
- jr_addr  input  32  register jump address.
- pc  output  32  current fetch address.
- pc_valid  output  1  `pc` is a live fetch this cycle.
- state  output  2  encoded state: IDLE=00, RUN=01, STALL=10, HALT=11.
- retired  output  CNT_W  count of RUN cycles that advanced the PC.
- trap  output  1  misaligned-jr trap flag (see Optional Feature).

Behaviour:
- Reset (`reset`=0, asynchronous):
  - `pc`=RESET_VEC, `pc_valid`=0, `state`=IDLE, `retired`=0, `trap`=0.
  - Release is synchronous to the next `clk` edge.
- IDLE:
  - `pc_valid`=0; `pc` held.
  - `boot`=1 → `pc` <= {pc_in[31:2],2'b00}, `state` <= RUN.
  - `pc_valid`=1 from the following cycle.
- RUN (`pc_valid`=1). Input priority per cycle, highest first:
  - `halt_req` → HALT; `pc` held; `pc_valid`=0 next cycle.
  - `stall` → STALL; `pc` held.
  - `jr` → `pc` <= {jr_addr[31:2],2'b00}.
  - `jump` → `pc` <= {pc4[31:28], jump_target, 2'b00}.
  - `branch_taken` → `pc` <= pc4 + (sign_extend(branch_off) << 2).
  - otherwise → `pc` <= pc4.
  - In the rules above, pc4 = pc + 4.
- Arithmetic and width rules:
  - All addition is modulo 2^32: pc=32'hFFFF_FFFC wraps to 32'h0000_0000.
  - Negative offsets wrap the same way.
- `retired` counting:
  - Increments by 1 on every RUN cycle whose next state is RUN; stall and halt cycles do not count.
  - Saturates at all-ones and does not wrap.
- `boot` while in RUN or STALL is ignored.
- STALL:
  - `pc_valid`=0; `pc` held.
  - Redirect inputs are ignored.
  - `stall`=0 → RUN with `pc` unchanged, so the stalled instruction re-fetches.
  - `halt_req` has priority over leaving STALL → HALT.
- HALT:
  - `pc_valid`=0; `pc` held at the last fetched address.
  - Only `boot`=1 exits: loads `pc_in`, → RUN, clears `trap`.
  - `retired` is retained.
- Simultaneous `boot` and `halt_req` in IDLE or HALT: `boot` wins.
- Reset asserted mid-operation, in any state: immediate return to the reset values.
- Latency:
  - Every control input sampled at edge N affects `pc` and `state` at edge N.
  - The result is visible one cycle later; there is no combinational path from inputs to `pc`.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - In RUN with `jr`=1 and jr_addr[1:0]≠00 → `state` <= HALT and `trap` <= 1.
  - `pc` holds the address of the jr instruction.
  - `trap` is sticky until `boot` or reset.
  - The trap outranks `stall` and ranks below `halt_req`.
- Not defined:
  - jr_addr[1:0] is silently masked.
  - `trap` is tied to 0.

Test Plan:
1. Reset low → `pc`=32'h0, `state`=00, `pc_valid`=0. Raise reset, pulse `boot` with `pc_in`=32'h8000_0F00 → next cycle `pc`=32'h8000_0F00, `state`=01. Three idle cycles → `pc`=32'h8000_0F0C, `retired`=3.
2. At `pc`=32'h0000_0100, pulse `branch_taken` with `branch_off`=16'hFFFE → `pc`=32'h0000_00FC. Then `jump` with `jump_target`=26'h0000040 → `pc`=32'h0000_0100.
3. Assert `stall` for 3 cycles at `pc`=32'h0000_0200 with `jump`=1 held → `pc` stays 32'h0000_0200, `pc_valid`=0, `retired` unchanged. Release `stall` → RUN at 32'h0000_0200.
4. Assert `halt_req`, `jr` and `stall` together → HALT, `pc` unchanged. Pulse `boot` with `pc_in`=32'h0000_0013 → `pc`=32'h0000_0010, RUN.
5. Boot at `pc_in`=32'hFFFF_FFFC, one sequential step → `pc`=32'h0000_0000. Assert reset mid-RUN → `pc`=RESET_VEC and `retired`=0 without a clock edge.
6. `jr` with `jr_addr`=32'h0000_1002:
   - MISALIGN_TRAP_EN defined → HALT, `trap`=1, `pc` held.
   - Not defined → `pc`=32'h0000_1000, `trap`=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter controller for the MIPS single-cycle datapath. Loads a
// boot vector, then advances the PC sequentially or redirects it on branch,
// jump or register-jump. Holds the PC on stall and stops fetch on halt.
// `pc` is a register and drives the instruction memory address directly.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined     : a jr to a non-word-aligned address halts and sets `trap`
//   not defined : jr_addr[1:0] is masked and `trap` stays 0
//
// Parameters
//   RESET_VEC   PC value while in reset and in IDLE
//   CNT_W       width of the retired-instruction counter
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   asynchronous active-low reset
//   boot          in   start pulse, loads pc_in from IDLE or HALT
//   pc_in         in   boot vector (word aligned on load)
//   stall         in   hold PC, instruction re-issues
//   halt_req      in   stop fetching
//   branch_taken  in   conditional branch resolved taken
//   branch_off    in   signed word offset
//   jump          in   J-type jump
//   jump_target   in   J-type target field
//   jr            in   register jump
//   jr_addr       in   register jump address
//   pc            out  current fetch address
//   pc_valid      out  pc is a live fetch this cycle
//   state         out  IDLE=00 RUN=01 STALL=10 HALT=11
//   retired       out  saturating count of RUN cycles that advanced the PC
//   trap          out  sticky misaligned-jr trap flag
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | after reset, waiting for boot; pc = RESET_VEC
// RUN   | fetching; pc advances or redirects every cycle
// STALL | pc held, fetch suppressed until stall drops
// HALT  | fetch stopped, pc holds last fetched address; boot restarts
// ---------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             boot,
    input  logic [31:0]      pc_in,
    input  logic             stall,
    input  logic             halt_req,
    input  logic             branch_taken,
    input  logic [15:0]      branch_off,
    input  logic             jump,
    input  logic [25:0]      jump_target,
    input  logic             jr,
    input  logic [31:0]      jr_addr,
    output logic [31:0]      pc,
    output logic             pc_valid,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             trap
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_STALL = 2'b10,
        S_HALT  = 2'b11
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               trap_q, trap_d;

    logic [31:0]        pc4;
    logic [31:0]        br_off_ext;
    logic [31:0]        br_tgt;
    logic [31:0]        jmp_tgt;
    logic [31:0]        jr_tgt;
    logic [31:0]        boot_tgt;
    logic               jr_misalign;
    logic               unused_lsbs;

    // All address arithmetic is 32-bit and wraps modulo 2^32.
    assign pc4        = pc_q + 32'd4;
    assign br_off_ext = {{14{branch_off[15]}}, branch_off, 2'b00};
    assign br_tgt     = pc4 + br_off_ext;
    assign jmp_tgt    = {pc4[31:28], jump_target, 2'b00};
    assign jr_tgt     = {jr_addr[31:2], 2'b00};
    assign boot_tgt   = {pc_in[31:2], 2'b00};

`ifdef MISALIGN_TRAP_EN
    assign jr_misalign = jr & (jr_addr[1:0] != 2'b00);
`else
    assign jr_misalign = 1'b0;
`endif

    // Address low bits are dropped by word alignment.
    assign unused_lsbs = ^{pc_in[1:0], jr_addr[1:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_VEC;
            retired_q <= '0;
            trap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            trap_q    <= trap_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        trap_d    = trap_q;

        unique case (state_q)
            S_IDLE: begin
                if (boot) begin
                    pc_d    = boot_tgt;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                if (halt_req) begin
                    state_d = S_HALT;
                end else if (jr_misalign) begin
                    // pc keeps the address of the offending jr
                    state_d = S_HALT;
                    trap_d  = 1'b1;
                end else if (stall) begin
                    state_d = S_STALL;
                end else begin
                    if (jr) begin
                        pc_d = jr_tgt;
                    end else if (jump) begin
                        pc_d = jmp_tgt;
                    end else if (branch_taken) begin
                        pc_d = br_tgt;
                    end else begin
                        pc_d = pc4;
                    end
                    if (retired_q != {CNT_W{1'b1}}) begin
                        retired_d = retired_q + 1'b1;
                    end
                end
            end

            S_STALL: begin
                // Redirects and boot are ignored; pc re-fetches on release.
                if (halt_req) begin
                    state_d = S_HALT;
                end else if (!stall) begin
                    state_d = S_RUN;
                end
            end

            S_HALT: begin
                if (boot) begin
                    pc_d    = boot_tgt;
                    state_d = S_RUN;
                    trap_d  = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign pc       = pc_q;
    assign pc_valid = (state_q == S_RUN);
    assign state    = state_q;
    assign retired  = retired_q;
    assign trap     = trap_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    localparam int          CW   = 4;
    localparam logic [31:0] RVEC = 32'h0000_0000;
    localparam int ST_IDLE  = 0;
    localparam int ST_RUN   = 1;
    localparam int ST_STALL = 2;
    localparam int ST_HALT  = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          boot, stall, halt_req, branch_taken, jump, jr;
    logic [31:0]   pc_in, jr_addr;
    logic [15:0]   branch_off;
    logic [25:0]   jump_target;
    logic [31:0]   pc;
    logic          pc_valid;
    logic [1:0]    state;
    logic [CW-1:0] retired;
    logic          trap;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_pc   = RVEC;
    int          m_st   = ST_IDLE;
    int          m_ret  = 0;
    bit          m_trap = 1'b0;

    pc_sequencer #(.RESET_VEC(RVEC), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .boot(boot), .pc_in(pc_in),
        .stall(stall), .halt_req(halt_req), .branch_taken(branch_taken),
        .branch_off(branch_off), .jump(jump), .jump_target(jump_target),
        .jr(jr), .jr_addr(jr_addr), .pc(pc), .pc_valid(pc_valid),
        .state(state), .retired(retired), .trap(trap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Spec-level next-state rule evaluated on each rising edge.
    task automatic model_step();
        bit misalign;
        longint tgt;
`ifdef MISALIGN_TRAP_EN
        misalign = jr && (jr_addr % 4 != 0);
`else
        misalign = 1'b0;
`endif
        if (m_st == ST_IDLE || m_st == ST_HALT) begin
            if (boot) begin
                m_pc   = pc_in & ~32'h3;
                m_st   = ST_RUN;
                m_trap = 1'b0;
            end
        end else if (m_st == ST_STALL) begin
            if (halt_req)    m_st = ST_HALT;
            else if (!stall) m_st = ST_RUN;
        end else begin
            if (halt_req) m_st = ST_HALT;
            else if (misalign) begin
                m_st   = ST_HALT;
                m_trap = 1'b1;
            end else if (stall) m_st = ST_STALL;
            else begin
                if (jr)
                    tgt = longint'(jr_addr) & 64'hFFFF_FFFC;
                else if (jump)
                    tgt = (longint'(m_pc + 32'd4) & 64'hF000_0000) + longint'(jump_target) * 4;
                else if (branch_taken)
                    tgt = longint'(m_pc) + 4 + longint'($signed(branch_off)) * 4;
                else
                    tgt = longint'(m_pc) + 4;
                m_pc = tgt[31:0];
                if (m_ret < (1 << CW) - 1) m_ret++;
            end
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pc = RVEC; m_st = ST_IDLE; m_ret = 0; m_trap = 1'b0;
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        chk("cyc_pc",       pc,                     m_pc);
        chk("cyc_state",    {30'd0, state},         32'(m_st));
        chk("cyc_pc_valid", {31'd0, pc_valid},      {31'd0, (m_st == ST_RUN)});
        chk("cyc_retired",  {{(32-CW){1'b0}}, retired}, 32'(m_ret));
        chk("cyc_trap",     {31'd0, trap},          {31'd0, m_trap});
    end

    task automatic clr();
        boot = 0; stall = 0; halt_req = 0; branch_taken = 0; jump = 0; jr = 0;
        pc_in = 32'h0; jr_addr = 32'h0; branch_off = 16'h0; jump_target = 26'h0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        clr();
        #1 reset = 1'b0;
        #2;
        chk("rst_pc",       pc,                 32'h0);
        chk("rst_state",    {30'd0, state},     32'd0);
        chk("rst_pc_valid", {31'd0, pc_valid},  32'd0);
        chk("rst_retired",  {28'd0, retired},   32'd0);
        chk("rst_trap",     {31'd0, trap},      32'd0);
        tick(1);
        reset = 1'b1;

        // boot and sequential advance
        boot = 1; pc_in = 32'h8000_0F00;
        tick(1);
        chk("boot_pc",    pc,             32'h8000_0F00);
        chk("boot_state", {30'd0, state}, 32'd1);
        clr();
        tick(3);
        chk("seq_pc",      pc,               32'h8000_0F0C);
        chk("seq_retired", {28'd0, retired}, 32'd3);

        // branch backwards, then jump
        jr = 1; jr_addr = 32'h0000_0100;
        tick(1);
        chk("jr_pc", pc, 32'h0000_0100);
        clr(); branch_taken = 1; branch_off = 16'hFFFE;
        tick(1);
        chk("br_neg_pc", pc, 32'h0000_00FC);
        clr(); jump = 1; jump_target = 26'h0000040;
        tick(1);
        chk("jump_pc", pc, 32'h0000_0100);

        // stall with jump held
        clr(); jr = 1; jr_addr = 32'h0000_0200;
        tick(1);
        clr(); stall = 1; jump = 1; jump_target = 26'h0000100;
        tick(3);
        chk("stall_pc",      pc,                32'h0000_0200);
        chk("stall_valid",   {31'd0, pc_valid}, 32'd0);
        chk("stall_retired", {28'd0, retired},  32'd7);
        stall = 0;
        tick(1);
        chk("unstall_pc",    pc,             32'h0000_0200);
        chk("unstall_state", {30'd0, state}, 32'd1);
        tick(1);
        chk("after_unstall_jump", pc, 32'h0000_0400);

        // boot ignored in STALL, halt_req leaves STALL
        clr(); stall = 1; boot = 1; pc_in = 32'h0000_9000;
        tick(1);
        chk("stall_boot_ign", pc, 32'h0000_0400);
        halt_req = 1;
        tick(1);
        chk("stall_to_halt", {30'd0, state}, 32'd3);

        // boot beats halt_req in HALT
        clr(); boot = 1; halt_req = 1; pc_in = 32'h0000_0013;
        tick(1);
        chk("boot_wins_pc",    pc,               32'h0000_0010);
        chk("boot_wins_state", {30'd0, state},   32'd1);
        chk("halt_ret_kept",   {28'd0, retired}, 32'd8);

        // halt_req + jr + stall: halt wins
        clr(); halt_req = 1; jr = 1; jr_addr = 32'h0000_1234; stall = 1;
        tick(1);
        chk("halt_pri_state", {30'd0, state}, 32'd3);
        chk("halt_pri_pc",    pc,             32'h0000_0010);
        clr();
        tick(2);
        chk("halt_hold_pc", pc, 32'h0000_0010);
        boot = 1; pc_in = 32'h0000_0020;
        tick(1);
        pc_in = 32'h0000_5000;
        tick(1);
        chk("run_boot_ign", pc, 32'h0000_0024);

        // counter saturation
        clr();
        tick(7);
        chk("sat_retired", {28'd0, retired}, 32'd15);
        chk("sat_pc",      pc,               32'h0000_0040);

        // wrap-around
        halt_req = 1;
        tick(1);
        clr(); boot = 1; pc_in = 32'hFFFF_FFFC;
        tick(1);
        clr();
        tick(1);
        chk("wrap_pc", pc, 32'h0000_0000);
        branch_taken = 1; branch_off = 16'hFFFE;
        tick(1);
        chk("wrap_neg_br", pc, 32'hFFFF_FFFC);
        clr();
        tick(2);
        chk("pre_reset_pc", pc, 32'h0000_0004);

        // asynchronous reset mid-RUN
        #2 reset = 1'b0;
        #1;
        chk("async_rst_pc",      pc,               RVEC);
        chk("async_rst_retired", {28'd0, retired}, 32'd0);
        chk("async_rst_state",   {30'd0, state},   32'd0);
        tick(1);
        reset = 1'b1;

        // misaligned jr
        boot = 1; pc_in = 32'h0000_1000;
        tick(1);
        clr(); jr = 1; jr_addr = 32'h0000_1002;
        tick(1);
`ifdef MISALIGN_TRAP_EN
        chk("trap_state", {30'd0, state}, 32'd3);
        chk("trap_flag",  {31'd0, trap},  32'd1);
        chk("trap_pc",    pc,             32'h0000_1000);
        clr();
        tick(1);
        chk("trap_sticky", {31'd0, trap}, 32'd1);
        boot = 1; pc_in = 32'h0000_2000;
        tick(1);
        chk("trap_cleared", {31'd0, trap}, 32'd0);
        clr(); jr = 1; jr_addr = 32'h0000_2001; stall = 1;
        tick(1);
        chk("trap_over_stall", {30'd0, state}, 32'd3);
        clr(); boot = 1; pc_in = 32'h0000_3000;
        tick(1);
        clr(); jr = 1; jr_addr = 32'h0000_3003; halt_req = 1;
        tick(1);
        chk("halt_over_trap", {31'd0, trap}, 32'd0);
`else
        chk("mask_pc",    pc,             32'h0000_1000);
        chk("mask_trap",  {31'd0, trap},  32'd0);
        chk("mask_state", {30'd0, state}, 32'd1);
        jr_addr = 32'h0000_2003;
        tick(1);
        chk("mask_pc2", pc, 32'h0000_2000);
`endif
        clr();
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
